// File: rtl/port_pkg.sv
// Shared types for the buffered bidirectional port: FSM state encoding and
// direction codes used by the top and the bench.
package port_pkg;

   typedef enum logic {
      PS_RUN  = 1'b0,
      PS_TURN = 1'b1
   } port_state_e;

   localparam logic DIR_A2B = 1'b0;
   localparam logic DIR_B2A = 1'b1;

endpackage

// File: rtl/port_fifo.sv
// DEPTH-entry synchronous FIFO with push/pop gating and a synchronous flush.
// Head is the word at the read pointer and is valid whenever empty is low.
module port_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign do_push = push && !flush && (!full || pop);
   assign do_pop  = pop && !flush && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/buffered_bidir_port.sv
// Bidirectional port between two shared tristate buses with a FIFO in the path.
// A direction change flushes the FIFO and releases both buses for one dead cycle.
module buffered_bidir_port
   import port_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         dir,
   input  logic                         wr_en,
   input  logic                         rd_en,
   input  logic                         clr_err,
   inout  wire  [WIDTH-1:0]             bus_a,
   inout  wire  [WIDTH-1:0]             bus_b,
   output logic                         dir_q,
   output logic                         busy,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         ovf,
   output logic                         unf
);

   port_state_e      state;
   port_state_e      state_nxt;
   logic             dir_q_nxt;
   logic             flush;
   logic             run_ops;
   logic             push;
   logic             pop;
   logic             ovf_set;
   logic             unf_set;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] src_data;
   logic             sink_en;
   logic             drive_a;
   logic             drive_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PS_RUN;
         dir_q <= DIR_A2B;
      end else begin
         state <= state_nxt;
         dir_q <= dir_q_nxt;
      end
   end

   // A dir mismatch in RUN spends its cycle flushing; transfers only run when aligned.
   always_comb begin
      state_nxt = state;
      dir_q_nxt = dir_q;
      flush     = 1'b0;
      run_ops   = 1'b0;
      case (state)
         PS_RUN: begin
            if (dir != dir_q) begin
               state_nxt = PS_TURN;
               flush     = 1'b1;
            end else begin
               run_ops = 1'b1;
            end
         end
         PS_TURN: begin
            state_nxt = PS_RUN;
            dir_q_nxt = dir;
         end
         default: state_nxt = PS_RUN;
      endcase
   end

   assign busy = (state == PS_TURN);

   // wr_en and rd_en are single-cycle strobes sampled at posedge; rd_en means the
   // sink has taken the word currently on the bus, wr_en means the source word is valid.
   assign push    = wr_en && run_ops;
   assign pop     = rd_en && run_ops;
   assign ovf_set = push && full && !rd_en;
   assign unf_set = pop && empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= ovf_set | (ovf & ~clr_err);
         unf <= unf_set | (unf & ~clr_err);
      end
   end

   assign src_data = (dir_q == DIR_A2B) ? bus_a : bus_b;

   port_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (src_data),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // rst_n gates the drivers directly so the buses release without waiting for a clock.
   assign sink_en = rst_n && (state == PS_RUN) && !empty;
   assign drive_a = sink_en && (dir_q == DIR_B2A);
   assign drive_b = sink_en && (dir_q == DIR_A2B);

   assign bus_a = drive_a ? head : {WIDTH{1'bz}};
   assign bus_b = drive_b ? head : {WIDTH{1'bz}};

endmodule

// File: tb/tb_buffered_bidir_port.sv
// Self-checking bench for buffered_bidir_port: a queue-based reference model
// fed at each posedge and a negedge monitor comparing the DUT against it.
module tb_buffered_bidir_port;
   import port_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             dir = 1'b0;
   logic             wr_en = 1'b0;
   logic             rd_en = 1'b0;
   logic             clr_err = 1'b0;
   logic [WIDTH-1:0] src_val = '0;
   logic             tb_drive = 1'b0;
   wire  [WIDTH-1:0] bus_a;
   wire  [WIDTH-1:0] bus_b;
   logic             dir_q, busy, full, empty, ovf, unf;
   logic [CW-1:0]    count;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [WIDTH-1:0] exp_q[$];
   int               m_count = 0;
   logic             m_dir_q = DIR_A2B;
   logic             m_turn = 1'b0;
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;
   logic             m_push_ok, m_pop_ok, m_ovf_set, m_unf_set;

   logic             a_oe, b_oe;
   logic [WIDTH-1:0] sink, src;
   logic [WIDTH-1:0] zval;

   assign zval  = {WIDTH{1'bz}};
   assign a_oe  = tb_drive && !m_turn && (m_dir_q == DIR_A2B);
   assign b_oe  = tb_drive && !m_turn && (m_dir_q == DIR_B2A);
   assign bus_a = a_oe ? src_val : {WIDTH{1'bz}};
   assign bus_b = b_oe ? src_val : {WIDTH{1'bz}};

   buffered_bidir_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dir     (dir),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .clr_err (clr_err),
      .bus_a   (bus_a),
      .bus_b   (bus_b),
      .dir_q   (dir_q),
      .busy    (busy),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .ovf     (ovf),
      .unf     (unf)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, count and flags from the rules.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_count = 0;
         m_dir_q = DIR_A2B;
         m_turn  = 1'b0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
      end else if (m_turn) begin
         m_turn  = 1'b0;
         m_dir_q = dir;
         if (clr_err) begin m_ovf = 1'b0; m_unf = 1'b0; end
      end else if (dir != m_dir_q) begin
         m_turn  = 1'b1;
         exp_q.delete();
         m_count = 0;
         if (clr_err) begin m_ovf = 1'b0; m_unf = 1'b0; end
      end else begin
         m_push_ok = wr_en && ((m_count < DEPTH) || rd_en);
         m_pop_ok  = rd_en && (m_count > 0);
         m_ovf_set = wr_en && (m_count == DEPTH) && !rd_en;
         m_unf_set = rd_en && (m_count == 0);
         if (m_push_ok) exp_q.push_back(src_val);
         m_count = m_count + (m_push_ok ? 1 : 0) - (m_pop_ok ? 1 : 0);
         m_ovf = m_ovf_set || (m_ovf && !clr_err);
         m_unf = m_unf_set || (m_unf && !clr_err);
      end
   end

   // Monitor / scoreboard: compare at negedge, pop when the sink consumes the head.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy",  32'(busy),  32'(m_turn));
         check("dir_q", 32'(dir_q), 32'(m_dir_q));
         check("count", 32'(count), 32'(m_count));
         check("full",  32'(full),  32'(m_count == DEPTH));
         check("empty", 32'(empty), 32'(m_count == 0));
         check("ovf",   32'(ovf),   32'(m_ovf));
         check("unf",   32'(unf),   32'(m_unf));
         if (m_turn) begin
            check("turn_bus_a_z", 32'(bus_a), 32'(zval));
            check("turn_bus_b_z", 32'(bus_b), 32'(zval));
         end else begin
            sink = (m_dir_q == DIR_A2B) ? bus_b : bus_a;
            src  = (m_dir_q == DIR_A2B) ? bus_a : bus_b;
            check("source_bus", 32'(src), tb_drive ? 32'(src_val) : 32'(zval));
            if (exp_q.size() > 0) begin
               check("sink_head", 32'(sink), 32'(exp_q[0]));
               if (rd_en && (dir == m_dir_q)) void'(exp_q.pop_front());
            end else begin
               check("sink_idle_z", 32'(sink), 32'(zval));
            end
         end
      end
   end

   // driver: one call = one clock cycle with these inputs
   task automatic drive(input logic w, input logic r, input logic c, input logic [WIDTH-1:0] d);
      wr_en   = w;
      rd_en   = r;
      clr_err = c;
      src_val = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, WIDTH'($urandom_range(0, 255)));
   endtask

   task automatic settle_dir(input logic target);
      dir = target;
      for (int i = 0; i < 8 && !((m_dir_q == target) && !m_turn); i++) idle();
      check("dir_settle", 32'(dir_q), 32'(target));
   endtask

   initial begin
      rst_n = 1'b0;
      tb_drive = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_bus_a_z", 32'(bus_a), 32'(zval));
      check("rst_bus_b_z", 32'(bus_b), 32'(zval));
      check("rst_count",   32'(count), 32'd0);
      check("rst_empty",   32'(empty), 32'd1);
      check("rst_full",    32'(full),  32'd0);
      check("rst_dir_q",   32'(dir_q), 32'd0);
      check("rst_busy",    32'(busy),  32'd0);
      check("rst_flags",   32'({ovf, unf}), 32'd0);
      rst_n = 1'b1;
      tb_drive = 1'b1;
      idle();

      // A->B fill and overflow
      drive(1, 0, 0, 8'h11);
      check("first_word_b", 32'(bus_b), 32'h11);
      drive(1, 0, 0, 8'h22);
      drive(1, 0, 0, 8'h33);
      drive(1, 0, 0, 8'h44);
      check("fill_full",  32'(full),  32'd1);
      check("fill_count", 32'(count), 32'd4);
      drive(1, 0, 0, 8'h66);
      check("ovf_set",   32'(ovf),   32'd1);
      check("ovf_count", 32'(count), 32'd4);

      // drain, underflow, clear
      repeat (4) drive(0, 1, 0, 8'h00);
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_b_z",   32'(bus_b), 32'(zval));
      drive(0, 1, 0, 8'h00);
      check("unf_set", 32'(unf), 32'd1);
      drive(0, 0, 1, 8'h00);
      check("clr_flags", 32'({ovf, unf}), 32'd0);

      // full with simultaneous push and pop
      drive(1, 0, 0, 8'h01);
      drive(1, 0, 0, 8'h02);
      drive(1, 0, 0, 8'h03);
      drive(1, 0, 0, 8'h04);
      drive(1, 1, 0, 8'h55);
      check("pp_count", 32'(count), 32'd4);
      check("pp_ovf",   32'(ovf),   32'd0);
      check("pp_head",  32'(bus_b), 32'h02);

      // turnaround with 2 words queued
      drive(0, 1, 0, 8'h00);
      drive(0, 1, 0, 8'h00);
      check("pre_turn_count", 32'(count), 32'd2);
      dir = 1'b1;
      idle();
      check("turn_busy",  32'(busy),  32'd1);
      check("turn_count", 32'(count), 32'd0);
      check("turn_a_z",   32'(bus_a), 32'(zval));
      check("turn_b_z",   32'(bus_b), 32'(zval));
      idle();
      check("post_turn_dir_q", 32'(dir_q), 32'd1);
      drive(1, 0, 0, 8'hA5);
      check("b2a_word", 32'(bus_a), 32'hA5);
      drive(0, 1, 0, 8'h00);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) dir = ~dir;
         drive(logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 9) == 0), WIDTH'($urandom_range(0, 255)));
      end

      // reset mid-stream while driving bus_b with three words queued
      settle_dir(~dir);
      settle_dir(DIR_A2B);
      drive(0, 0, 1, 8'h00);
      drive(1, 0, 0, 8'hC1);
      drive(1, 0, 0, 8'hC2);
      drive(1, 0, 0, 8'hC3);
      wr_en = 1'b0;
      check("mid_count", 32'(count), 32'd3);
      check("mid_bus_b", 32'(bus_b), 32'hC1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_bus_b_z", 32'(bus_b), 32'(zval));
      check("arst_count",   32'(count), 32'd0);
      check("arst_empty",   32'(empty), 32'd1);
      check("arst_full",    32'(full),  32'd0);
      check("arst_dir_q",   32'(dir_q), 32'd0);
      check("arst_busy",    32'(busy),  32'd0);
      check("arst_flags",   32'({ovf, unf}), 32'd0);
      dir = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
